// File: rtl/sid_regfile_arbiter.sv
// SID register file with CPU/player write arbitration, a player write FIFO and
// an atomic shadow-to-output commit on every ce_1m tick.
module sid_regfile_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           ce_1m,
    input  logic           cpu_we,
    input  logic           cpu_rd,
    input  logic [4:0]     cpu_addr,
    input  logic [7:0]     cpu_wdata,
    output logic [7:0]     cpu_rdata,
    input  logic           pl_valid,
    output logic           pl_ready,
    input  logic [4:0]     pl_addr,
    input  logic [7:0]     pl_data,
    input  logic [7:0]     osc3_in,
    input  logic [7:0]     env3_in,
    output logic [167:0]   voice_regs,
    output logic [31:0]    filt_regs,
    output logic [LVL_W-1:0] fifo_level
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    logic [199:0]     shadow_q, shadow_d, commit_q, commit_d;
    logic [2:0]       gate_pend_q, gate_pend_d, gate_set_s;
    logic [7:0]       rdata_q, rdata_d, rd_mux_s;
    logic [4:0]       fifo_addr_q [FIFO_DEPTH];
    logic [7:0]       fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_s, push_s, pop_s, wr_en_s;
    logic [4:0]       wr_addr_s;
    logic [7:0]       wr_data_s;

    assign ready_s    = ~reset & (level_q < DEPTH_L);
    assign push_s     = pl_valid & ready_s;
    assign pl_ready   = ready_s;
    assign fifo_level = level_q;
    assign cpu_rdata  = rdata_q;
    assign voice_regs = commit_q[167:0];
    assign filt_regs  = commit_q[199:168];

    // The CPU always wins; the FIFO head drains only in CPU-idle cycles.
    always_comb begin
        wr_en_s   = 1'b0;
        pop_s     = 1'b0;
        wr_addr_s = cpu_addr;
        wr_data_s = cpu_wdata;
        if (cpu_we) begin
            wr_en_s = 1'b1;
        end else if (level_q != {LVL_W{1'b0}}) begin
            wr_en_s   = 1'b1;
            pop_s     = 1'b1;
            wr_addr_s = fifo_addr_q[rd_ptr_q];
            wr_data_s = fifo_data_q[rd_ptr_q];
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1'b1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1'b1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1'b1);
            2'b01:   level_d = level_q - LVL_W'(1'b1);
            default: level_d = level_q;
        endcase
    end

    // Shadow write, gate-low tracking and commit of the pre-write shadow.
    always_comb begin
        shadow_d   = shadow_q;
        commit_d   = commit_q;
        gate_set_s = 3'b000;
        if (wr_en_s && (wr_addr_s < 5'd25)) begin
            shadow_d[{wr_addr_s, 3'b000} +: 8] = wr_data_s;
        end else begin
            shadow_d = shadow_q;
        end
        for (int v = 0; v < 3; v++) begin
            if (wr_en_s && (wr_addr_s == 5'(7 * v + 4)) && !wr_data_s[0]) begin
                gate_set_s[v] = 1'b1;
            end else begin
                gate_set_s[v] = 1'b0;
            end
        end
        if (ce_1m) begin
            commit_d = shadow_q;
            // A gate that dropped during the period must be seen low for one sample.
            for (int v = 0; v < 3; v++) begin
                if (gate_pend_q[v]) begin
                    commit_d[56 * v + 32] = 1'b0;
                end else begin
                    commit_d[56 * v + 32] = shadow_q[56 * v + 32];
                end
            end
        end else begin
            commit_d = commit_q;
        end
        gate_pend_d = (ce_1m ? 3'b000 : gate_pend_q) | gate_set_s;
    end

    // CPU readback mux; only voice 3 oscillator and envelope are readable.
    always_comb begin
        case (cpu_addr)
            5'h1B:   rd_mux_s = osc3_in;
            5'h1C:   rd_mux_s = env3_in;
            default: rd_mux_s = 8'h00;
        endcase
        rdata_d = cpu_rd ? rd_mux_s : rdata_q;
    end

    // State registers with synchronous reset; reset also flushes the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q    <= 200'd0;
            commit_q    <= 200'd0;
            gate_pend_q <= 3'b000;
            rdata_q     <= 8'h00;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            level_q     <= {LVL_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_addr_q[i] <= 5'd0;
                fifo_data_q[i] <= 8'h00;
            end
        end else begin
            shadow_q    <= shadow_d;
            commit_q    <= commit_d;
            gate_pend_q <= gate_pend_d;
            rdata_q     <= rdata_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            if (push_s) begin
                fifo_addr_q[wr_ptr_q] <= pl_addr;
                fifo_data_q[wr_ptr_q] <= pl_data;
            end
        end
    end
endmodule

// File: tb/tb_sid_regfile_arbiter.sv
// Bench for sid_regfile_arbiter: directed scenarios plus randomized traffic
// checked against a byte-array/queue reference model.
module tb_sid_regfile_arbiter;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset, ce_1m, cpu_we, cpu_rd, pl_valid;
    logic [4:0]   cpu_addr, pl_addr;
    logic [7:0]   cpu_wdata, pl_data, osc3_in, env3_in;
    logic [7:0]   cpu_rdata;
    logic         pl_ready;
    logic [167:0] voice_regs;
    logic [31:0]  filt_regs;
    logic [2:0]   fifo_level;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  m_shadow [25];
    logic [7:0]  m_comm   [25];
    logic [2:0]  m_pend;
    logic [12:0] m_q [$];
    logic [7:0]  m_rdata;

    sid_regfile_arbiter #(.FIFO_DEPTH(DEPTH), .LVL_W(3)) dut (
        .clock(clock), .reset(reset), .ce_1m(ce_1m), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_addr(pl_addr), .pl_data(pl_data),
        .osc3_in(osc3_in), .env3_in(env3_in), .voice_regs(voice_regs),
        .filt_regs(filt_regs), .fifo_level(fifo_level)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic void model_write(logic [4:0] a, logic [7:0] d);
        if (a < 5'd25) m_shadow[a] = d;
        for (int v = 0; v < 3; v++)
            if (int'(a) == 7 * v + 4 && d[0] == 1'b0) m_pend[v] = 1'b1;
    endfunction

    function automatic void model_step();
        logic rdy;
        logic [12:0] e;
        rdy = !reset && (m_q.size() < DEPTH);
        if (reset) begin
            for (int a = 0; a < 25; a++) begin m_shadow[a] = 8'h00; m_comm[a] = 8'h00; end
            m_pend = 3'b000; m_rdata = 8'h00; m_q.delete();
        end else begin
            if (cpu_rd) m_rdata = (cpu_addr == 5'h1B) ? osc3_in : (cpu_addr == 5'h1C) ? env3_in : 8'h00;
            if (ce_1m) begin
                for (int a = 0; a < 25; a++) m_comm[a] = m_shadow[a];
                for (int v = 0; v < 3; v++) begin
                    if (m_pend[v] && m_shadow[7 * v + 4][0]) m_comm[7 * v + 4][0] = 1'b0;
                    m_pend[v] = 1'b0;
                end
            end
            if (cpu_we) model_write(cpu_addr, cpu_wdata);
            else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                model_write(e[12:8], e[7:0]);
            end
            if (pl_valid && rdy) m_q.push_back({pl_addr, pl_data});
        end
    endfunction

    function automatic logic [167:0] exp_voice();
        logic [167:0] r;
        for (int a = 0; a < 21; a++) r[8 * a +: 8] = m_comm[a];
        return r;
    endfunction

    function automatic logic [31:0] exp_filt();
        logic [31:0] r;
        for (int a = 0; a < 4; a++) r[8 * a +: 8] = m_comm[21 + a];
        return r;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ce_1m = 1'b0; cpu_we = 1'b0; cpu_rd = 1'b0; pl_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle();
        cpu_addr = 5'd0; cpu_wdata = 8'h00; pl_addr = 5'd0; pl_data = 8'h00;
        osc3_in = 8'h00; env3_in = 8'h00;
        tick(); tick();
        checks++; if (voice_regs !== 168'd0) begin failures++; $display("FAIL reset_voice got %h exp 0", voice_regs); end
        checks++; if (filt_regs !== 32'd0) begin failures++; $display("FAIL reset_filt got %h exp 0", filt_regs); end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got %h exp 00", cpu_rdata); end
        checks++; if (pl_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b exp 0", pl_ready); end
        reset = 1'b0;
        #1;
        checks++; if (pl_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %b exp 1", pl_ready); end
        tick();
    endtask

    task automatic test_atomic_commit();
        cpu_we = 1'b1; cpu_addr = 5'h00; cpu_wdata = 8'h34; tick();
        checks++; if (voice_regs[15:0] !== 16'h0000) begin failures++; $display("FAIL atomic_mid1 got %h exp 0000", voice_regs[15:0]); end
        cpu_addr = 5'h01; cpu_wdata = 8'h12; tick();
        cpu_we = 1'b0; tick();
        checks++; if (voice_regs[15:0] !== 16'h0000) begin failures++; $display("FAIL atomic_mid2 got %h exp 0000", voice_regs[15:0]); end
        ce_1m = 1'b1; tick(); ce_1m = 1'b0;
        checks++; if (voice_regs[15:0] !== 16'h1234) begin failures++; $display("FAIL atomic_commit got %h exp 1234", voice_regs[15:0]); end
    endtask

    task automatic test_player_burst();
        logic [4:0] a [5];
        logic [7:0] d [5];
        int i = 0, low = 0, peak = 0, guard = 0;
        a[0] = 5'h07; a[1] = 5'h08; a[2] = 5'h09; a[3] = 5'h0A; a[4] = 5'h07;
        for (int k = 0; k < 5; k++) d[k] = 8'($urandom_range(1, 255));
        while (i < 5 && guard < 30) begin
            logic was;
            pl_valid = 1'b1; pl_addr = a[i]; pl_data = d[i];
            was = pl_ready;
            if (!was) low++;
            tick();
            if (was) i++;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            guard++;
        end
        pl_valid = 1'b0;
        checks++; if (i != 5) begin failures++; $display("FAIL burst_accept got %0d exp 5", i); end
        guard = 0;
        while (fifo_level != 3'd0 && guard < 20) begin tick(); guard++; end
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL burst_drain got %0d exp 0", fifo_level); end
        checks++; if (low > 1) begin failures++; $display("FAIL burst_ready_low got %0d exp <=1", low); end
        checks++; if (peak > DEPTH) begin failures++; $display("FAIL burst_peak got %0d exp <=4", peak); end
        ce_1m = 1'b1; tick(); ce_1m = 1'b0;
        checks++; if (voice_regs[63:56] !== d[4]) begin failures++; $display("FAIL burst_order got %h exp %h", voice_regs[63:56], d[4]); end
        checks++; if (voice_regs[87:64] !== {d[3], d[2], d[1]}) begin failures++; $display("FAIL burst_bytes got %h exp %h", voice_regs[87:64], {d[3], d[2], d[1]}); end
    endtask

    task automatic test_cpu_priority();
        logic [7:0] last;
        cpu_we = 1'b1; cpu_addr = 5'h04;
        pl_valid = 1'b1; pl_addr = 5'h0B; pl_data = 8'h41;
        for (int c = 0; c < 10; c++) begin
            last = 8'($urandom_range(0, 255)) | 8'h01;
            cpu_wdata = last;
            tick();
            pl_valid = 1'b0;
            checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL prio_wait c%0d got %0d exp 1", c, fifo_level); end
        end
        cpu_we = 1'b0; tick();
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL prio_drain got %0d exp 0", fifo_level); end
        ce_1m = 1'b1; tick(); ce_1m = 1'b0;
        checks++; if (voice_regs[95:88] !== 8'h41) begin failures++; $display("FAIL prio_player got %h exp 41", voice_regs[95:88]); end
        checks++; if (voice_regs[39:32] !== last) begin failures++; $display("FAIL prio_cpu got %h exp %h", voice_regs[39:32], last); end
    endtask

    task automatic test_gate_retrigger();
        ce_1m = 1'b1; tick(); ce_1m = 1'b0;
        cpu_we = 1'b1; cpu_addr = 5'h04;
        cpu_wdata = 8'h11; tick();
        cpu_wdata = 8'h10; tick();
        cpu_wdata = 8'h11; tick();
        cpu_we = 1'b0; ce_1m = 1'b1; tick();
        checks++; if (voice_regs[39:32] !== 8'h10) begin failures++; $display("FAIL gate_forced_low got %h exp 10", voice_regs[39:32]); end
        tick();
        ce_1m = 1'b0;
        checks++; if (voice_regs[39:32] !== 8'h11) begin failures++; $display("FAIL gate_release got %h exp 11", voice_regs[39:32]); end
    endtask

    task automatic test_same_cycle_commit();
        cpu_we = 1'b1; cpu_addr = 5'h05; cpu_wdata = 8'h00; tick();
        cpu_we = 1'b0; ce_1m = 1'b1; tick();
        cpu_we = 1'b1; cpu_wdata = 8'hAA; tick();
        cpu_we = 1'b0; ce_1m = 1'b0;
        checks++; if (voice_regs[47:40] !== 8'h00) begin failures++; $display("FAIL samecyc_hidden got %h exp 00", voice_regs[47:40]); end
        tick();
        checks++; if (voice_regs[47:40] !== 8'h00) begin failures++; $display("FAIL samecyc_hold got %h exp 00", voice_regs[47:40]); end
        ce_1m = 1'b1; tick(); ce_1m = 1'b0;
        checks++; if (voice_regs[47:40] !== 8'hAA) begin failures++; $display("FAIL samecyc_next got %h exp aa", voice_regs[47:40]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(0, 79) == 0);
            ce_1m     = ($urandom_range(0, 7) == 0);
            cpu_we    = ($urandom_range(0, 9) < 3);
            cpu_rd    = ($urandom_range(0, 3) == 0);
            cpu_addr  = 5'($urandom_range(0, 31));
            cpu_wdata = 8'($urandom_range(0, 255));
            pl_valid  = ($urandom_range(0, 9) < 6);
            pl_addr   = 5'($urandom_range(0, 31));
            pl_data   = 8'($urandom_range(0, 255));
            osc3_in   = 8'($urandom_range(0, 255));
            env3_in   = 8'($urandom_range(0, 255));
            tick();
            checks++; if (voice_regs !== exp_voice()) begin failures++; $display("FAIL rnd_voice c%0d got %h exp %h", c, voice_regs, exp_voice()); end
            checks++; if (filt_regs !== exp_filt()) begin failures++; $display("FAIL rnd_filt c%0d got %h exp %h", c, filt_regs, exp_filt()); end
            checks++; if (int'(fifo_level) != m_q.size()) begin failures++; $display("FAIL rnd_level c%0d got %0d exp %0d", c, fifo_level, m_q.size()); end
            checks++; if (pl_ready !== (!reset && m_q.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready c%0d got %b", c, pl_ready); end
            checks++; if (cpu_rdata !== m_rdata) begin failures++; $display("FAIL rnd_rdata c%0d got %h exp %h", c, cpu_rdata, m_rdata); end
        end
        reset = 1'b0; idle(); tick();
    endtask

    task automatic test_reset_flush();
        cpu_we = 1'b1; cpu_addr = 5'h19; cpu_wdata = 8'hFF;
        pl_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pl_addr = 5'(k); pl_data = 8'h55 + 8'(k);
            tick();
        end
        checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL flush_pending got %0d exp 3", fifo_level); end
        reset = 1'b1; cpu_we = 1'b0; ce_1m = 1'b1;
        tick();
        checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL flush_level got %0d exp 0", fifo_level); end
        checks++; if ({voice_regs, filt_regs} !== 200'd0) begin failures++; $display("FAIL flush_outputs got %h exp 0", {voice_regs, filt_regs}); end
        checks++; if (pl_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got %b exp 0", pl_ready); end
        reset = 1'b0; idle(); tick(); tick();
        ce_1m = 1'b1; tick(); ce_1m = 1'b0;
        checks++; if (voice_regs !== 168'd0) begin failures++; $display("FAIL flush_lost got %h exp 0", voice_regs); end
        cpu_rd = 1'b1; cpu_addr = 5'h1B; osc3_in = 8'h7E; tick();
        cpu_rd = 1'b0;
        checks++; if (cpu_rdata !== 8'h7E) begin failures++; $display("FAIL read_osc3 got %h exp 7e", cpu_rdata); end
        osc3_in = 8'h11; tick();
        checks++; if (cpu_rdata !== 8'h7E) begin failures++; $display("FAIL read_hold got %h exp 7e", cpu_rdata); end
        cpu_rd = 1'b1; cpu_addr = 5'h00; tick();
        cpu_rd = 1'b0;
        checks++; if (cpu_rdata !== 8'h00) begin failures++; $display("FAIL read_wo got %h exp 00", cpu_rdata); end
        cpu_rd = 1'b1; cpu_addr = 5'h1C; env3_in = 8'hC3; tick();
        cpu_rd = 1'b0;
        checks++; if (cpu_rdata !== 8'hC3) begin failures++; $display("FAIL read_env3 got %h exp c3", cpu_rdata); end
    endtask

    initial begin
        test_reset();
        test_atomic_commit();
        test_player_burst();
        test_cpu_priority();
        test_gate_retrigger();
        test_same_cycle_commit();
        test_random();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sid_regfile_arbiter.md
Name: sid_regfile_arbiter

Overview:
- Owns the SID register file (3 voices plus filter) and arbitrates writes from two requesters: the CPU bus and a hardware register player (digi/tune-replay engine).
- Writes land in a shadow bank. The whole bank is committed atomically to the voice-facing outputs on each ce_1m tick, so multi-byte fields (freq, pw, fc) never tear mid-sample.
- Sits between the CPU/player fabric and the three sid_voice_8580 instances plus the filter.

Parameters:
- FIFO_DEPTH, 4, player write FIFO entries (power of two, ≥2)
- LVL_W, 3, width of fifo_level (must hold 0..FIFO_DEPTH)

Ports:
- clock  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- ce_1m  in  1  1 MHz sample strobe, one clock wide; commit point
- cpu_we  in  1  CPU write strobe
- cpu_rd  in  1  CPU read strobe
- cpu_addr  in  5  CPU register address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, registered
- pl_valid  in  1  player write request
- pl_ready  out  1  player handshake; high when FIFO not full
- pl_addr  in  5  player register address
- pl_data  in  8  player write data
- osc3_in  in  8  voice 3 osc_out, for readback
- env3_in  in  8  voice 3 env_out, for readback
- voice_regs  out  168  committed voice registers; voice n occupies bits [56n+55:56n]; byte order low→high is freq_lo, freq_hi, pw_lo, pw_hi, control, att_dec, sus_rel
- filt_regs  out  32  committed fc_lo, fc_hi, res_filt, mode_vol (low→high)
- fifo_level  out  LVL_W  current player FIFO occupancy

Behaviour:
- Address map:
  - 0x00–0x06 voice 0; 0x07–0x0D voice 1; 0x0E–0x14 voice 2.
  - 0x15–0x18 filter.
  - Writes to 0x19–0x1F are discarded.
- Reads (cpu_rd sampled at cycle t; cpu_rdata valid at t+1):
  - 0x1B → osc3_in; 0x1C → env3_in.
  - All other addresses → 0x00 (write-only).
  - cpu_rdata holds its value until the next cpu_rd.
- Player FIFO:
  - Entry pushed when pl_valid && pl_ready.
  - pl_ready = (level < FIFO_DEPTH), combinational from the registered level.
  - pl_ready is 0 while reset is high.
  - Push and pop in the same cycle leave the level unchanged. A push is accepted when full only if... never: ready is low when full, so no push occurs.
- Arbitration, per clock:
  - cpu_we has absolute priority and is applied to shadow the same cycle. The CPU is never stalled.
  - The FIFO head is popped and applied only in cycles with cpu_we=0 and FIFO non-empty.
  - Player writes are applied in FIFO order.
- Shadow update: the shadow byte takes the new value at the clock edge ending the write cycle.
- Commit:
  - In a cycle with ce_1m=1, voice_regs/filt_regs take the shadow contents as they stood at the start of that cycle.
  - A write applied in the same cycle as ce_1m goes into shadow but is committed at the next ce_1m.
  - Outputs never change except at commit edges or reset.
- Gate retrigger, per voice (control bit 0):
  - gate_low_pend[v] is set when any shadow write to control[v] carries bit0=0.
  - At commit, if gate_low_pend[v] is set and shadow bit0=1, the committed bit0 is forced to 0 (other control bits taken normally). gate_low_pend[v] then clears and the following commit passes bit0=1.
  - If shadow bit0=0 at commit, the flag just clears.
  - Result: a 1→0→1 gate within one sample period is guaranteed to give the envelope one sample of gate low.
- Reset (any cycle, including mid-FIFO drain):
  - Shadow, committed outputs, gate_low_pend, cpu_rdata and fifo_level all go to 0.
  - FIFO is flushed; pending player entries are lost.
  - ce_1m, cpu_we and pl_valid are ignored while reset is high.

Test Plan:
- Reset, then CPU writes 0x00=0x34 and 0x01=0x12 between ce_1m ticks → voice_regs[15:0] stays 0x0000 until the next ce_1m, then reads 0x1234 in one step; no intermediate 0x0034.
- Player pushes 5 writes back-to-back with FIFO_DEPTH=4 and no CPU activity → pl_ready low for at most one cycle; all 5 reach shadow in order; fifo_level peaks at ≤4.
- CPU write to 0x04 on every cycle for 10 cycles while the player pushes 0x0B=0x41 → player entry waits; applied the first cycle cpu_we=0; fifo_level returns to 0.
- Within one sample period, CPU writes control 0x04: 0x11, 0x10, 0x11 → next commit voice_regs[39:32]=0x10; the commit after gives 0x11.
- Write 0x05=0xAA in the same cycle as ce_1m → not visible at that commit; visible at the next commit.
- Assert reset with 3 FIFO entries pending; CPU reads 0x1B with osc3_in=0x7E after reset → outputs all 0, fifo_level=0, entries lost, cpu_rdata=0x7E one cycle after the read; a read of 0x00 returns 0x00.
